pc_stack_unit: RTL and testbench

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/pc_stack_unit_if.sv | 29 ++
 rtl/pc_stack_unit.sv | 109 ++++++++++
 tb/tb_pc_stack_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pc_stack_unit_if.sv
// Bus between the PC/return-stack unit and its consumer: mode/target inputs plus PC and stack status.
interface pc_stack_unit_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [2:0]       PS;
  logic [WIDTH-1:0] in;
  logic             en;
  logic             clr_fault;
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] PC4;
  logic [CW-1:0]    sp_count;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;

  modport master (
    output PS, in, en, clr_fault,
    input  address, PC4, sp_count, full, empty, ovf, unf
  );

  modport slave (
    input  PS, in, en, clr_fault,
    output address, PC4, sp_count, full, empty, ovf, unf
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with relative/absolute jumps, calls and returns backed by a circular return-address stack.
module pc_stack_unit #(
  parameter int unsigned    WIDTH        = 64,
  parameter int unsigned    DEPTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic            clock,
  input  logic            reset,
  pc_stack_unit_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] PS_HOLD     = 3'b000;
  localparam logic [2:0] PS_REG      = 3'b010;
  localparam logic [2:0] PS_REL      = 3'b011;
  localparam logic [2:0] PS_CALL_REL = 3'b100;
  localparam logic [2:0] PS_CALL_REG = 3'b101;
  localparam logic [2:0] PS_RET      = 3'b110;

  logic [WIDTH-1:0] address_q, address_d;
  logic [AW-1:0]    wp_q, wp_d, wp_prev;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push;
  logic             full, empty;
  logic [WIDTH-1:0] pc4, rel_target;
  logic [WIDTH-1:0] stack [DEPTH];

  assign pc4        = address_q + WIDTH'(4);
  assign rel_target = address_q + (bus.in << 2);
  assign wp_prev    = wp_q - AW'(1);
  assign full       = (cnt_q == CW'(DEPTH));
  assign empty      = (cnt_q == CW'(0));

  // Next-state decode; a push when full overwrites the oldest slot since wp wraps onto it.
  always_comb begin
    address_d = address_q;
    wp_d      = wp_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push      = 1'b0;
    if (bus.en) begin
      case (bus.PS)
        PS_HOLD:     address_d = address_q;
        PS_REG:      address_d = bus.in;
        PS_REL:      address_d = rel_target;
        PS_CALL_REL: begin
          push      = 1'b1;
          address_d = rel_target;
        end
        PS_CALL_REG: begin
          push      = 1'b1;
          address_d = bus.in;
        end
        PS_RET: begin
          if (empty) begin
            address_d = pc4;
            unf_d     = 1'b1;
          end else begin
            address_d = stack[wp_prev];
            wp_d      = wp_prev;
            cnt_d     = cnt_q - CW'(1);
          end
        end
        default:     address_d = pc4;
      endcase
      if (push) begin
        wp_d = wp_q + AW'(1);
        if (full) ovf_d = 1'b1;
        else      cnt_d = cnt_q + CW'(1);
      end
    end
    if (bus.clr_fault) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      address_q <= RESET_VECTOR;
      wp_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      address_q <= address_d;
      wp_q      <= wp_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Stack storage carries no reset; writes are suppressed while reset is held.
  always_ff @(posedge clock) begin
    if (push && reset) stack[wp_q] <= pc4;
  end

  assign bus.address  = address_q;
  assign bus.PC4      = pc4;
  assign bus.sp_count = cnt_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed and random checks of pc_stack_unit against a queue-based return-stack model.
module tb_pc_stack_unit;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 8;
  localparam logic [63:0] RV    = 64'h0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [63:0] m_addr;
  logic [63:0] m_q[$];
  logic        m_ovf, m_unf;

  pc_stack_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pc_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = RV;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_push(input logic [63:0] v);
    m_q.push_back(v);
    if (m_q.size() > DEPTH) begin
      void'(m_q.pop_front());
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_update(input logic [2:0] ps, input logic [63:0] v, input logic e, input logic clr);
    logic [63:0] nxt;
    if (e) begin
      case (ps)
        3'd0: nxt = m_addr;
        3'd2: nxt = v;
        3'd3: nxt = m_addr + v * 4;
        3'd4: begin model_push(m_addr + 4); nxt = m_addr + v * 4; end
        3'd5: begin model_push(m_addr + 4); nxt = v; end
        3'd6: begin
          if (m_q.size() == 0) begin nxt = m_addr + 4; m_unf = 1'b1; end
          else nxt = m_q.pop_back();
        end
        default: nxt = m_addr + 4;
      endcase
      m_addr = nxt;
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ":address"}, bus.address, m_addr);
    chk({tag, ":PC4"}, bus.PC4, m_addr + 4);
    chk({tag, ":sp_count"}, 64'(bus.sp_count), 64'(m_q.size()));
    chk({tag, ":full"}, 64'(bus.full), 64'(m_q.size() == DEPTH));
    chk({tag, ":empty"}, 64'(bus.empty), 64'(m_q.size() == 0));
    chk({tag, ":ovf"}, 64'(bus.ovf), 64'(m_ovf));
    chk({tag, ":unf"}, 64'(bus.unf), 64'(m_unf));
  endtask

  task automatic step(input logic [2:0] ps, input logic [63:0] v, input logic e, input logic clr);
    bus.PS        = ps;
    bus.in        = v;
    bus.en        = e;
    bus.clr_fault = clr;
    model_update(ps, v, e, clr);
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [63:0] v;
    longint      sv;
    bus.PS = 3'd0; bus.in = '0; bus.en = 1'b0; bus.clr_fault = 1'b0;
    model_reset();

    // Asynchronous reset before any clock edge
    #1 reset = 1'b0;
    #1 check_model("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    check_model("post_reset");

    for (int i = 1; i <= 3; i++) begin
      step(3'd1, '0, 1'b1, 1'b0);
      check_model("inc");
      chk("inc_abs", bus.address, 64'(4 * i));
    end

    step(3'd2, 64'h100, 1'b1, 1'b0);
    step(3'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
    check_model("rel_neg");
    chk("rel_neg_abs", bus.address, 64'hF8);
    step(3'd2, 64'h2000, 1'b1, 1'b0);
    chk("reg_abs", bus.address, 64'h2000);

    step(3'd2, 64'h40, 1'b1, 1'b0);
    step(3'd4, 64'd4, 1'b1, 1'b0);
    check_model("call_rel");
    chk("call_rel_abs", bus.address, 64'h50);
    step(3'd5, 64'h800, 1'b1, 1'b0);
    check_model("call_reg");
    chk("call_reg_cnt", 64'(bus.sp_count), 64'd2);
    step(3'd6, '0, 1'b1, 1'b0);
    chk("ret1_abs", bus.address, 64'h54);
    step(3'd6, '0, 1'b1, 1'b0);
    check_model("ret2");
    chk("ret2_abs", bus.address, 64'h44);
    chk("ret2_empty", 64'(bus.empty), 64'd1);

    // Overflow with nine calls, then drain past empty
    for (int k = 1; k <= 9; k++) begin
      step(3'd2, 64'(k) * 64'h1000, 1'b1, 1'b0);
      step(3'd5, 64'h9000, 1'b1, 1'b0);
    end
    check_model("ovf");
    chk("ovf_flag", 64'(bus.ovf), 64'd1);
    chk("ovf_full", 64'(bus.full), 64'd1);
    for (int k = 9; k >= 2; k--) begin
      step(3'd6, '0, 1'b1, 1'b0);
      chk("drain_abs", bus.address, 64'(k) * 64'h1000 + 64'd4);
    end
    step(3'd6, '0, 1'b1, 1'b0);
    check_model("unf");
    chk("unf_abs", bus.address, 64'h2008);
    chk("unf_flag", 64'(bus.unf), 64'd1);
    step(3'd0, '0, 1'b0, 1'b1);
    check_model("clr");

    step(3'd4, 64'd1, 1'b0, 1'b0);
    step(3'd4, 64'd1, 1'b0, 1'b0);
    check_model("en_low");
    chk("en_low_abs", bus.address, 64'h2008);

    for (int k = 0; k < 3; k++) step(3'd5, 64'h300, 1'b1, 1'b0);
    check_model("three_calls");
    bus.en = 1'b0;
    #1 reset = 1'b0;
    #1;
    model_reset();
    check_model("mid_reset");
    chk("mid_reset_cnt", 64'(bus.sp_count), 64'd0);
    reset = 1'b1;

    // Reset held across a call edge aborts the push
    step(3'd5, 64'h700, 1'b1, 1'b0);
    bus.PS = 3'd5; bus.in = 64'h500; bus.en = 1'b1;
    @(negedge clock);
    #4 reset = 1'b0;
    @(posedge clock);
    #1;
    bus.en = 1'b0;
    reset = 1'b1;
    model_reset();
    check_model("reset_on_call");

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        v = {$urandom, $urandom};
      end else begin
        sv = longint'($urandom_range(0, 200)) - 64'sd100;
        v  = 64'(sv);
      end
      step(3'($urandom_range(0, 7)), v, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0);
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
